// File: rtl/cu_pkg.sv
// -----------------------------------------------------------------------------
// cu_pkg
// Shared types and helpers for the microcode sequencer.
//   cu_state_t      : sequencer state (FETCH, DECODE, EXEC, OPERAND, COMMIT)
//   CU_IN_W/CU_OUT_W: default inflag/outflag field widths
//   uc_*            : field positions inside a microcode word laid out as
//                     [FETCH | LAST | out | in], MSB first
// -----------------------------------------------------------------------------
package cu_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXEC    = 3'd2,
    OPERAND = 3'd3,
    COMMIT  = 3'd4
  } cu_state_t;

  localparam int CU_IN_W  = 4;
  localparam int CU_OUT_W = 3;

  // Field positions are functions so every instance derives them from its own
  // IN_W/OUT_W and a different ISA only swaps the ROM contents and widths.
  function automatic int uc_out_lsb(input int in_w);
    return in_w;
  endfunction

  function automatic int uc_last_bit(input int in_w, input int out_w);
    return in_w + out_w;
  endfunction

  function automatic int uc_fetch_bit(input int in_w, input int out_w);
    return in_w + out_w + 1;
  endfunction

endpackage

// File: rtl/cu_pc.sv
// -----------------------------------------------------------------------------
// cu_pc
// Program counter with increment, load and a registered increment pulse.
//   clk, rst     : clock, asynchronous active-high reset
//   i_inc        : advance the PC by one (modulo 2^PC_W)
//   i_load       : load the PC from i_load_addr (never coincides with i_inc)
//   i_load_addr  : load target
//   o_pc         : program counter
//   o_pc_inc     : one-cycle pulse, high while o_pc shows the incremented value
// -----------------------------------------------------------------------------
module cu_pc #(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_inc,
  input  logic            i_load,
  input  logic [PC_W-1:0] i_load_addr,
  output logic [PC_W-1:0] o_pc,
  output logic            o_pc_inc
);

  logic [PC_W-1:0] r_pc;
  logic            r_pc_inc;

  // NOTE: state registers use non-blocking assignments so every register in
  // the design samples the pre-edge values; the reset is in the sensitivity
  // list because it is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= '0;
      r_pc_inc <= 1'b0;
    end else begin
      r_pc_inc <= i_inc;
      if (i_load)
        r_pc <= i_load_addr;
      else if (i_inc)
        r_pc <= r_pc + PC_W'(1);  // all-ones wraps to zero
    end
  end

  assign o_pc     = r_pc;
  assign o_pc_inc = r_pc_inc;

endmodule

// File: rtl/cu_seq.sv
// -----------------------------------------------------------------------------
// cu_seq
// Microcode sequencer: fetches an opcode over the SPI handshake, then steps
// through up to N_PHASES microcode words per instruction. Each word drives
// the flag fields, may fetch an operand byte, and may end the instruction.
//   clk, rst      : clock, asynchronous active-high reset
//   halt          : stop at the next instruction boundary
//   spi_req/done  : memory handshake (level request, one-cycle done pulse)
//   irin          : opcode/operand byte, valid with spi_done
//   ucode_addr    : registered {ir, phase} address into the external ROM
//   ucode_data    : ROM word [FETCH | LAST | out | in]
//   jump_valid/addr : PC load, honoured only in COMMIT
//   pc, pc_inc    : program counter and its increment pulse
//   ir            : current opcode
//   inflags, outflags : control fields
//   halted        : stopped at an instruction boundary
// -----------------------------------------------------------------------------
module cu_seq
  import cu_pkg::*;
#(
  parameter int               PC_W      = 16,
  parameter int               IR_W      = 8,
  parameter int               N_PHASES  = 4,
  parameter int               IN_W      = CU_IN_W,
  parameter int               OUT_W     = CU_OUT_W,
  parameter logic [IN_W-1:0]  FETCH_IN  = 4'h0,
  parameter logic [OUT_W-1:0] FETCH_OUT = 3'h5,
  localparam int              PH_W      = (N_PHASES > 1) ? $clog2(N_PHASES) : 1,
  localparam int              UC_W      = 2 + OUT_W + IN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 halt,
  output logic                 spi_req,
  input  logic                 spi_done,
  input  logic [IR_W-1:0]      irin,
  output logic [IR_W+PH_W-1:0] ucode_addr,
  input  logic [UC_W-1:0]      ucode_data,
  input  logic                 jump_valid,
  input  logic [PC_W-1:0]      jump_addr,
  output logic [PC_W-1:0]      pc,
  output logic                 pc_inc,
  output logic [IR_W-1:0]      ir,
  output logic [IN_W-1:0]      inflags,
  output logic [OUT_W-1:0]     outflags,
  output logic                 halted
);

  localparam int OUT_LSB   = uc_out_lsb(IN_W);
  localparam int LAST_BIT  = uc_last_bit(IN_W, OUT_W);
  localparam int FETCH_BIT = uc_fetch_bit(IN_W, OUT_W);

  cu_state_t       r_state;
  logic [IR_W-1:0] r_ir;
  logic [PH_W-1:0] r_phase;
  logic            r_last_q;
  logic            r_spi_req;
  logic            r_halted;
  logic            r_fetch_flags;  // fetch flags shown (non-halted FETCH)

  logic             w_uc_fetch;
  logic             w_uc_last;
  logic [OUT_W-1:0] w_uc_out;
  logic [IN_W-1:0]  w_uc_in;
  logic             w_last_phase;
  logic             w_pc_inc;
  logic             w_pc_load;

  assign w_uc_fetch   = ucode_data[FETCH_BIT];
  assign w_uc_last    = ucode_data[LAST_BIT];
  assign w_uc_out     = ucode_data[OUT_LSB +: OUT_W];
  assign w_uc_in      = ucode_data[IN_W-1:0];
  assign w_last_phase = (r_phase == PH_W'(N_PHASES - 1));

  // A done pulse only counts where a transfer can be outstanding.
  assign w_pc_inc  = spi_done && (((r_state == FETCH) && !r_halted) ||
                                  (r_state == OPERAND));
  assign w_pc_load = (r_state == COMMIT) && jump_valid;

  cu_pc #(.PC_W(PC_W)) u_pc (
    .clk         (clk),
    .rst         (rst),
    .i_inc       (w_pc_inc),
    .i_load      (w_pc_load),
    .i_load_addr (jump_addr),
    .o_pc        (pc),
    .o_pc_inc    (pc_inc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= FETCH;
      r_ir          <= '0;
      r_phase       <= '0;
      r_last_q      <= 1'b0;
      r_spi_req     <= 1'b0;
      r_halted      <= 1'b0;
      r_fetch_flags <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (r_halted) begin
            // Fetch resumes (request and flags) on the cycle after halt falls.
            r_halted      <= halt;
            r_spi_req     <= !halt;
            r_fetch_flags <= !halt;
          end else if (spi_done) begin
            r_ir          <= irin;
            r_spi_req     <= 1'b0;
            r_fetch_flags <= 1'b0;
            r_state       <= DECODE;
          end else begin
            r_spi_req     <= 1'b1;
            r_fetch_flags <= 1'b1;
          end
        end

        DECODE: begin
          r_phase <= '0;
          r_state <= EXEC;
        end

        EXEC: begin
          if (w_uc_fetch) begin
            // Remember whether the operand fetch also ends the instruction.
            r_last_q <= w_uc_last || w_last_phase;
            r_state  <= OPERAND;
          end else if (w_uc_last || w_last_phase) begin
            r_state <= COMMIT;
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end

        OPERAND: begin
          if (spi_done) begin
            r_spi_req <= 1'b0;
            if (r_last_q) begin
              r_state <= COMMIT;
            end else begin
              r_phase <= r_phase + PH_W'(1);
              r_state <= EXEC;
            end
          end else begin
            r_spi_req <= 1'b1;
          end
        end

        COMMIT: begin
          // halt is only honoured here, at the instruction boundary.
          r_halted      <= halt;
          r_fetch_flags <= !halt;
          r_spi_req     <= 1'b0;
          r_state       <= FETCH;
        end

        default: r_state <= FETCH;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    inflags  = '0;
    outflags = '0;
    if (r_state == EXEC) begin
      inflags  = w_uc_in;
      outflags = w_uc_out;
    end else if (r_fetch_flags) begin
      inflags  = FETCH_IN;
      outflags = FETCH_OUT;
    end
  end

  assign spi_req    = r_spi_req;
  assign halted     = r_halted;
  assign ir         = r_ir;
  assign ucode_addr = {r_ir, r_phase};

endmodule

// File: tb/tb_cu_seq.sv
// -----------------------------------------------------------------------------
// tb_cu_seq
// Self-checking bench for cu_seq. A ROM array feeds ucode_data; each
// instruction is walked by the bench from the microcode rules (phase walk,
// operand count, jump, halt), with random ROM contents, SPI latencies,
// jumps and halts, plus directed reset, jump, halt and PC-wrap cases.
// -----------------------------------------------------------------------------
module tb_cu_seq;

  localparam int PC_W = 16, IR_W = 8, N_PHASES = 4, IN_W = 4, OUT_W = 3;
  localparam int PH_W = 2, UC_W = 9;
  localparam logic [IN_W-1:0]  F_IN  = 4'h0;
  localparam logic [OUT_W-1:0] F_OUT = 3'h5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 halt;
  logic                 spi_req;
  logic                 spi_done;
  logic [IR_W-1:0]      irin;
  logic [IR_W+PH_W-1:0] ucode_addr;
  logic [UC_W-1:0]      ucode_data;
  logic                 jump_valid;
  logic [PC_W-1:0]      jump_addr;
  logic [PC_W-1:0]      pc;
  logic                 pc_inc;
  logic [IR_W-1:0]      ir;
  logic [IN_W-1:0]      inflags;
  logic [OUT_W-1:0]     outflags;
  logic                 halted;

  logic [UC_W-1:0] rom [0:1023];

  cu_seq #(
    .PC_W(PC_W), .IR_W(IR_W), .N_PHASES(N_PHASES), .IN_W(IN_W), .OUT_W(OUT_W),
    .FETCH_IN(F_IN), .FETCH_OUT(F_OUT)
  ) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .spi_req(spi_req), .spi_done(spi_done), .irin(irin),
    .ucode_addr(ucode_addr), .ucode_data(ucode_data),
    .jump_valid(jump_valid), .jump_addr(jump_addr),
    .pc(pc), .pc_inc(pc_inc), .ir(ir),
    .inflags(inflags), .outflags(outflags), .halted(halted)
  );

  always #5 clk = ~clk;
  assign ucode_data = rom[ucode_addr];

  int              n_chk = 0;
  int              n_err = 0;
  int              inc_cnt = 0;
  logic [PC_W-1:0] exp_pc;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are observed on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (pc_inc) inc_cnt++;
  endtask

  // Wait for spi_req (bounded), then answer after 'delay' cycles.
  task automatic spi_xfer(input logic [IR_W-1:0] data, input int delay);
    int n = 0;
    while (!spi_req && n < 20) begin
      tick();
      n++;
    end
    check("spi_req_seen", spi_req, 1);
    repeat (delay) tick();
    spi_done = 1'b1;
    irin     = data;
    tick();
    spi_done = 1'b0;
    irin     = IR_W'($urandom);
  endtask

  // Runs one instruction starting in a non-halted FETCH cycle and ends in the
  // next non-halted FETCH cycle.
  task automatic run_instr(input logic [IR_W-1:0] op, input logic jv,
                           input logic [PC_W-1:0] ja, input logic hlt);
    int             p = 0;
    int             n_ops = 0;
    int             start_inc;
    bit             fin = 1'b0;
    logic [UC_W-1:0] w;

    check("fetch_flags", {inflags, outflags}, {F_IN, F_OUT});
    check("fetch_halted", halted, 0);
    start_inc = inc_cnt;
    spi_xfer(op, $urandom_range(0, 3));

    // DECODE
    exp_pc = exp_pc + PC_W'(1);
    check("pc_fetch", pc, exp_pc);
    check("pc_inc_fetch", pc_inc, 1);
    check("ir", ir, op);
    check("dec_req", spi_req, 0);
    check("dec_flags", {inflags, outflags}, 0);
    jump_valid = 1'b1;              // ignored outside COMMIT
    jump_addr  = PC_W'($urandom);
    halt       = 1'(hlt ? 1'b0 : 1'($urandom));
    tick();

    while (!fin) begin
      w = rom[{op, PH_W'(p)}];
      check("uaddr", ucode_addr, {op, PH_W'(p)});
      check("exec_in", inflags, w[IN_W-1:0]);
      check("exec_out", outflags, w[IN_W +: OUT_W]);
      check("exec_req", spi_req, 0);
      halt      = hlt ? 1'b1 : 1'($urandom);
      jump_addr = PC_W'($urandom);
      if (w[UC_W-1]) begin
        tick();
        check("oper_flags", {inflags, outflags}, 0);
        spi_xfer(IR_W'($urandom), $urandom_range(0, 3));
        n_ops++;
        exp_pc = exp_pc + PC_W'(1);
        check("pc_oper", pc, exp_pc);
        check("pc_inc_oper", pc_inc, 1);
      end else begin
        tick();
      end
      if (w[UC_W-2] || p == N_PHASES - 1) fin = 1'b1;
      else p++;
    end

    // COMMIT
    check("commit_flags", {inflags, outflags}, 0);
    check("commit_req", spi_req, 0);
    check("inc_count", inc_cnt - start_inc, 1 + n_ops);
    jump_valid = jv;
    jump_addr  = ja;
    halt       = hlt;
    tick();
    jump_valid = 1'b0;
    if (jv) exp_pc = ja;
    check("pc_commit", pc, exp_pc);
    check("pc_inc_commit", pc_inc, 0);
    check("halted", halted, hlt);
    check("entry_req", spi_req, 0);

    if (hlt) begin
      check("halt_flags", {inflags, outflags}, 0);
      repeat ($urandom_range(1, 3)) begin
        spi_done = 1'b1;          // stray pulse must be ignored
        irin     = IR_W'($urandom);
        tick();
        spi_done = 1'b0;
        check("hold_req", spi_req, 0);
        check("hold_halted", halted, 1);
        check("hold_pc", pc, exp_pc);
        check("hold_ir", ir, op);
        check("hold_flags", {inflags, outflags}, 0);
      end
      halt = 1'b0;
      tick();
      check("resume_halted", halted, 0);
      check("resume_req", spi_req, 1);
    end
  endtask

  initial begin
    rst        = 1'b1;
    halt       = 1'b0;
    spi_done   = 1'b0;
    irin       = '0;
    jump_valid = 1'b0;
    jump_addr  = '0;
    exp_pc     = '0;

    for (int i = 0; i < 1024; i++) rom[i] = UC_W'($urandom);
    // 0x12: ends on phase 0; later phases carry loud flags so a stray EXEC shows.
    rom[{8'h12, 2'd0}] = 9'b0_1_110_1011;
    rom[{8'h12, 2'd1}] = 9'b0_0_111_1111;
    rom[{8'h12, 2'd2}] = 9'b0_0_111_1111;
    rom[{8'h12, 2'd3}] = 9'b0_0_111_1111;
    // 0x34: operand on phases 0 and 2, ends on 2.
    rom[{8'h34, 2'd0}] = 9'b1_0_001_0001;
    rom[{8'h34, 2'd1}] = 9'b0_0_010_0010;
    rom[{8'h34, 2'd2}] = 9'b1_1_011_0011;
    rom[{8'h34, 2'd3}] = 9'b0_0_111_1111;
    // 0x56: single word, no operand.
    rom[{8'h56, 2'd0}] = 9'b0_1_100_0110;
    // 0x30: operand fetch on phase 0, used for the mid-OPERAND reset.
    rom[{8'h30, 2'd0}] = 9'b1_0_001_0001;

    repeat (2) @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_req", spi_req, 0);
    check("rst_flags", {inflags, outflags}, 0);
    check("rst_halted", halted, 0);
    check("rst_uaddr", ucode_addr, 0);
    rst = 1'b0;
    check("rel_req0", spi_req, 0);
    tick();
    check("rel_req1", spi_req, 1);

    // Reach pc=0x42 inside an OPERAND wait, then reset.
    run_instr(8'h01, 1'b1, 16'h0041, 1'b0);
    spi_xfer(8'h30, 1);
    check("pre_rst_pc", pc, 16'h0042);
    tick();  // EXEC
    tick();  // OPERAND, request not yet up
    tick();
    check("pre_rst_req", spi_req, 1);
    rst = 1'b1;
    #1;
    check("arst_pc", pc, 0);
    check("arst_ir", ir, 0);
    check("arst_uaddr", ucode_addr, 0);
    check("arst_req", spi_req, 0);
    check("arst_pc_inc", pc_inc, 0);
    check("arst_flags", {inflags, outflags}, 0);
    check("arst_halted", halted, 0);
    @(negedge clk);
    rst    = 1'b0;
    exp_pc = '0;
    check("post_req0", spi_req, 0);
    tick();
    check("post_req1", spi_req, 1);
    check("post_flags", {inflags, outflags}, {F_IN, F_OUT});

    run_instr(8'h12, 1'b0, 16'h0000, 1'b0);   // pc 0 -> 1, single EXEC
    run_instr(8'h34, 1'b1, 16'h000F, 1'b0);   // two operands, then pc=0x000F
    run_instr(8'h56, 1'b1, 16'hBEEF, 1'b0);   // pc 0x0010 then jump
    run_instr(8'h12, 1'b0, 16'h0000, 1'b1);   // halt raised during EXEC
    run_instr(8'h56, 1'b1, 16'hFFFF, 1'b0);
    run_instr(8'h12, 1'b0, 16'h0000, 1'b0);   // 0xFFFF wraps to 0x0000

    for (int i = 0; i < 40; i++) begin
      run_instr(IR_W'($urandom),
                $urandom_range(0, 3) == 0,
                PC_W'($urandom),
                $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Hard stop if the bench itself stalls.
  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/cu_seq.md
# cu_seq

Parametrised microcode sequencer that replaces the fixed two-phase control unit. It fetches an opcode over the SPI memory handshake, then steps through up to `N_PHASES` microcode words per instruction. Each word can drive flags, fetch an operand byte, or end the instruction early. It owns the program counter, runs on a single rising edge, and halts only at instruction boundaries.

## Interface
- `PC_W`, 16: program counter width.
- `IR_W`, 8: opcode width.
- `N_PHASES`, 4: maximum microcode words per instruction, at least 1. `PH_W = max(1, $clog2(N_PHASES))`.
- `IN_W`, 4: inflag field width.
- `OUT_W`, 3: outflag field width.
- `FETCH_IN`, 4'h0: inflags driven during opcode fetch.
- `FETCH_OUT`, 3'h5: outflags driven during opcode fetch.

Ports:
- `clk` in 1: clock, rising edge only.
- `rst` in 1: reset rst, asynchronous, active-high.
- `halt` in 1: request a stop at the next instruction boundary.
- `spi_req` out 1: fetch request, level.
- `spi_done` in 1: one-cycle completion pulse.
- `irin` in IR_W: opcode byte, valid with `spi_done` in FETCH.
- `ucode_addr` out IR_W+PH_W: registered `{ir, phase}`.
- `ucode_data` in 2+OUT_W+IN_W: combinational ROM read. Fields are `[FETCH | LAST | out | in]`, MSB first.
- `jump_valid` in 1: load the PC from `jump_addr`, sampled in COMMIT only.
- `jump_addr` in PC_W: jump target.
- `pc` out PC_W: program counter.
- `pc_inc` out 1: one-cycle pulse on each PC increment.
- `ir` out IR_W: current opcode.
- `inflags` out IN_W: inflag field.
- `outflags` out OUT_W: outflag field.
- `halted` out 1: high while stopped at a boundary.

## Operation
- States and their outputs:
  - FETCH: `spi_req=1` and fetch flags driven, unless halted.
  - DECODE: one-cycle bubble.
  - EXEC: microcode word applied.
  - OPERAND: `spi_req=1`, flags 0.
  - COMMIT: end of instruction.
- FETCH:
  - If `halt` is high on entry, stay in FETCH with `spi_req=0`, flags 0 and `halted=1`; the fetch starts the cycle after `halt` falls.
  - On `spi_done`: `ir<=irin`, `pc<=pc+1`, pulse `pc_inc`, go to DECODE.
- DECODE: `phase<=0`, flags 0, go to EXEC.
- EXEC:
  - `inflags` and `outflags` come straight from `ucode_data`.
  - If FETCH=1: latch `last_q = LAST | (phase==N_PHASES-1)` and go to OPERAND.
  - Else if LAST=1 or `phase==N_PHASES-1`: go to COMMIT.
  - Else `phase<=phase+1` and stay in EXEC.
- OPERAND: on `spi_done`: `pc<=pc+1`, pulse `pc_inc`. Then go to COMMIT if `last_q`, otherwise `phase<=phase+1` and go to EXEC.
- COMMIT:
  - If `jump_valid`: `pc<=jump_addr`.
  - Go to FETCH.
- Inflags and outflags are 0 in every state except EXEC and non-halted FETCH.
- PC arithmetic is modulo 2^PC_W: `{PC_W{1}}+1` wraps to 0, and `pc_inc` still pulses.
- `halt` is ignored mid-instruction: DECODE, EXEC, OPERAND and COMMIT always run to completion. Halting never loses a `spi_done`.
- `spi_done` outside FETCH or OPERAND, or during a halted FETCH, is ignored.
- `jump_valid` outside COMMIT is ignored.
- Reset, including mid-instruction or with `spi_req` high:
  - State returns to FETCH.
  - `pc`, `ir`, `phase`, `last_q` and `ucode_addr` are 0.
  - `spi_req`, `pc_inc`, flags and `halted` are 0.
  - A pending SPI transfer is abandoned.

## Timing
- `spi_req` rises the cycle after entering FETCH or OPERAND. It falls the cycle after `spi_done` is sampled, registered, when the state changes.
- `pc` and `ir` update on the edge that samples `spi_done`.
- `ucode_addr` is valid from the first EXEC cycle, since `phase` is registered in DECODE.
- An instruction of k phases with no operands takes `F+2+k` cycles: fetch wait F, DECODE, k EXEC cycles, COMMIT.
- Each operand adds `W+1` cycles, where W is the `spi_done` wait.
- A jump is visible on `pc` the cycle after COMMIT, the first FETCH cycle.
- `halted` rises the first FETCH cycle after a COMMIT that saw `halt` high.

## Structure
- Package `cu_pkg`: state enum `cu_state_t` (FETCH, DECODE, EXEC, OPERAND, COMMIT) and field-position localparams for `ucode_data`, derived from `IN_W` and `OUT_W`.
- One sub-module, `cu_pc`: PC register with increment, load, and the `pc_inc` pulse.
- The microcode ROM stays outside the block, so different ISAs swap only the ROM.

## Test plan
- Reset mid-OPERAND, with `pc=0x0042` and `spi_req=1`: all outputs return to 0 and state is FETCH. After release, `spi_req` rises one cycle later.
- Opcode 0x12 with LAST on phase 0, `N_PHASES=4`: exactly 1 EXEC cycle, `pc` goes 0→1, next FETCH starts. Check the flags on that EXEC cycle.
- Opcode with FETCH on phases 0 and 2 and LAST on 2: `pc` advances by 3 total, with `pc_inc` pulsing three times. `ucode_addr` phases run 0,1,2.
- Jump in COMMIT: `jump_valid=1`, `jump_addr=0xBEEF`, previous `pc=0x0010`. Result: `pc=0xBEEF` on the first FETCH cycle. `jump_valid` in EXEC has no effect.
- `halt` raised during EXEC: the instruction completes, then FETCH holds with `spi_req=0` and `halted=1`. A stray `spi_done` is ignored. Releasing `halt` resumes the fetch the next cycle.
- PC wrap: `pc=0xFFFF` with an opcode fetch gives `pc=0x0000` and a `pc_inc` pulse.
